// File: rtl/rtdf_sample_unpacker_if.sv
// Handshake bundle between the stream FIFO read side, the sample-rate tick
// and the unpacked sample output of rtdf_sample_unpacker.
interface rtdf_sample_unpacker_if #(
    parameter int SAMPLE_WIDTH = 2
);
    logic                    enable;
    logic                    fifo_empty;
    logic [15:0]             fifo_data;
    logic                    fifo_read_next;
    logic                    sample_strobe;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic                    sample_valid;
    logic                    underflow;
    logic [15:0]             underflow_count;

    modport master (
        output enable,
        output fifo_empty,
        output fifo_data,
        output sample_strobe,
        input  fifo_read_next,
        input  sample,
        input  sample_valid,
        input  underflow,
        input  underflow_count
    );

    modport slave (
        input  enable,
        input  fifo_empty,
        input  fifo_data,
        input  sample_strobe,
        output fifo_read_next,
        output sample,
        output sample_valid,
        output underflow,
        output underflow_count
    );
endinterface

// File: rtl/rtdf_sample_unpacker.sv
// Unpacks 16-bit stream FIFO words into SAMPLE_WIDTH-bit samples, one per strobe,
// with a two-word buffer to hide FIFO read latency and underflow reporting.
module rtdf_sample_unpacker #(
    parameter int SAMPLE_WIDTH = 2
) (
    input logic                  clk,
    input logic                  reset_n,
    rtdf_sample_unpacker_if.slave bus
);
    localparam int SPW = 16 / SAMPLE_WIDTH;
    localparam int IW  = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [IW-1:0] LAST = IW'(SPW - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [15:0]             cur_q, cur_d;
    logic [15:0]             next_q, next_d;
    logic                    cur_valid_q, cur_valid_d;
    logic                    next_valid_q, next_valid_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    pending_q;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                    sample_valid_q, sample_valid_d;
    logic                    underflow_q, underflow_d;
    logic [15:0]             ucnt_q, ucnt_d;

    logic                    read;
    logic                    flush;
    logic                    arrival;
    logic                    run_strobe;
    logic                    take;
    logic                    vacate;
    logic [15:0]             cur_shift;
    logic [SAMPLE_WIDTH-1:0] cur_sample;

    assign read = bus.enable && !bus.fifo_empty && !pending_q && !next_valid_q;

    // IDLE and a low enable both drop buffered words and any word in flight
    assign flush      = !bus.enable || (state_q == IDLE);
    assign arrival    = pending_q && !flush;
    assign run_strobe = (state_q == RUN) && bus.enable && bus.sample_strobe;
    assign take       = run_strobe && cur_valid_q;
    assign vacate     = take && (idx_q == LAST);

    assign cur_shift  = cur_q >> (32'(idx_q) * SAMPLE_WIDTH);
    assign cur_sample = cur_shift[SAMPLE_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.enable) state_d = PRIME;
            PRIME:   if (cur_valid_q && next_valid_q) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!bus.enable) state_d = IDLE;
    end

    always_comb begin
        cur_d          = cur_q;
        cur_valid_d    = cur_valid_q;
        next_d         = next_q;
        next_valid_d   = next_valid_q;
        idx_d          = idx_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        underflow_d    = 1'b0;
        ucnt_d         = ucnt_q;
        if (flush) begin
            cur_valid_d  = 1'b0;
            next_valid_d = 1'b0;
            idx_d        = '0;
        end else begin
            if (take) begin
                sample_d       = cur_sample;
                sample_valid_d = 1'b1;
                idx_d          = idx_q + 1'b1;
            end
            if (vacate) begin
                idx_d = '0;
                if (next_valid_q) begin
                    cur_d        = next_q;
                    next_valid_d = 1'b0;
                end else begin
                    cur_valid_d = 1'b0;
                end
            end
            // a word lands in cur only when nothing older is queued ahead of it
            if (arrival) begin
                if ((!cur_valid_q || vacate) && !next_valid_q) begin
                    cur_d       = bus.fifo_data;
                    cur_valid_d = 1'b1;
                    idx_d       = '0;
                end else begin
                    next_d       = bus.fifo_data;
                    next_valid_d = 1'b1;
                end
            end
            if (run_strobe && !cur_valid_q) begin
                underflow_d = 1'b1;
                if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_q          <= '0;
            next_q         <= '0;
            cur_valid_q    <= 1'b0;
            next_valid_q   <= 1'b0;
            idx_q          <= '0;
            pending_q      <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            underflow_q    <= 1'b0;
            ucnt_q         <= '0;
        end else begin
            cur_q          <= cur_d;
            next_q         <= next_d;
            cur_valid_q    <= cur_valid_d;
            next_valid_q   <= next_valid_d;
            idx_q          <= idx_d;
            pending_q      <= read;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            underflow_q    <= underflow_d;
            ucnt_q         <= ucnt_d;
        end
    end

    assign bus.fifo_read_next  = read;
    assign bus.sample          = sample_q;
    assign bus.sample_valid    = sample_valid_q;
    assign bus.underflow       = underflow_q;
    assign bus.underflow_count = ucnt_q;
endmodule

// File: tb/tb_rtdf_sample_unpacker.sv
// Self-checking bench for rtdf_sample_unpacker: FIFO model, sample-stream
// reference queue, table vectors and directed corner sequences.
module tb_rtdf_sample_unpacker;
    localparam int SW  = 2;
    localparam int SPW = 16 / SW;

    typedef struct {
        logic [15:0]   word;
        logic [SW-1:0] smp [SPW];
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   overread = 0;
    int   nvalid = 0;

    logic [15:0]   fifo_q [$];
    logic [SW-1:0] exp_q [$];
    logic [15:0]   ucnt_m;
    vec_t          tbl [6];

    rtdf_sample_unpacker_if #(.SAMPLE_WIDTH(SW)) bus ();

    rtdf_sample_unpacker #(.SAMPLE_WIDTH(SW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // one clock: FIFO pops on a read seen before the edge; q appears after it
    task automatic tick();
        logic rd;
        @(negedge clk);
        rd = bus.fifo_read_next;
        if (rd && bus.fifo_empty) overread++;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic fifo_push(input logic [15:0] w);
        fifo_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic model_push(input logic [15:0] w);
        fifo_push(w);
        for (int k = 0; k < SPW; k++)
            exp_q.push_back(SW'((w >> (k * SW)) & 16'((1 << SW) - 1)));
    endtask

    task automatic cyc_model(input logic strobe);
        logic [SW-1:0] e;
        bus.sample_strobe = strobe;
        tick();
        if (bus.sample_valid === 1'b1) nvalid++;
        if (strobe && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("m_valid", 32'(bus.sample_valid), 32'd1);
            chk("m_sample", 32'(bus.sample), 32'(e));
            chk("m_uflow", 32'(bus.underflow), 32'd0);
        end else if (strobe) begin
            if (ucnt_m != 16'hFFFF) ucnt_m = ucnt_m + 16'd1;
            chk("m_valid_uf", 32'(bus.sample_valid), 32'd0);
            chk("m_uflow_uf", 32'(bus.underflow), 32'd1);
        end else begin
            chk("m_valid_idle", 32'(bus.sample_valid), 32'd0);
            chk("m_uflow_idle", 32'(bus.underflow), 32'd0);
        end
        chk("m_ucnt", 32'(bus.underflow_count), 32'(ucnt_m));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sample"}, 32'(bus.sample), 32'd0);
        chk({tag, "_valid"}, 32'(bus.sample_valid), 32'd0);
        chk({tag, "_uflow"}, 32'(bus.underflow), 32'd0);
        chk({tag, "_ucnt"}, 32'(bus.underflow_count), 32'd0);
        chk({tag, "_rdnext"}, 32'(bus.fifo_read_next), 32'd0);
    endtask

    initial begin
        int pushed;
        int guard;
        int v0;

        tbl[0].word = 16'hE41B; tbl[0].smp = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        tbl[1].word = 16'h0000; tbl[1].smp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        tbl[2].word = 16'hFFFF; tbl[2].smp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        tbl[3].word = 16'hAAAA; tbl[3].smp = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        tbl[4].word = 16'h5555; tbl[4].smp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        tbl[5].word = 16'h1234; tbl[5].smp = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};

        reset_n           = 1'b1;
        bus.enable        = 1'b0;
        bus.fifo_empty    = 1'b1;
        bus.fifo_data     = '0;
        bus.sample_strobe = 1'b0;
        ucnt_m            = '0;
        #2 reset_n = 1'b0;
        #1;

        // reset state, FIFO loaded but enable low
        for (int i = 0; i < 6; i++) fifo_push(tbl[i].word);
        tick();
        tick();
        chk_zero("rst");
        reset_n = 1'b1;
        tick();
        chk("idle_rdnext", 32'(bus.fifo_read_next), 32'd0);

        // table vectors, strobe every 4 cycles
        bus.enable = 1'b1;
        repeat (6) cyc_model(1'b0);
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < SPW; k++) begin
                bus.sample_strobe = 1'b1;
                tick();
                chk("tbl_valid", 32'(bus.sample_valid), 32'd1);
                chk("tbl_sample", 32'(bus.sample), 32'(tbl[i].smp[k]));
                repeat (3) cyc_model(1'b0);
            end
        end
        cyc_model(1'b1);

        // back-to-back strobes over 64 words
        for (int i = 0; i < 64; i++) model_push(16'($urandom));
        repeat (6) cyc_model(1'b0);
        v0 = nvalid;
        repeat (512) cyc_model(1'b1);
        chk("b2b_count", 32'(nvalid - v0), 32'd512);
        cyc_model(1'b1);

        // random strobes while the FIFO is topped up, then drain
        pushed = 2;
        model_push(16'($urandom));
        model_push(16'($urandom));
        repeat (6) cyc_model(1'b0);
        guard = 0;
        while (!(pushed >= 40 && exp_q.size() == 0) && guard < 3000) begin
            if (pushed < 40 && fifo_q.size() < 2) begin
                model_push(16'($urandom));
                pushed++;
            end
            cyc_model(1'($urandom_range(0, 1)));
            guard++;
        end
        chk("rand_drain_in_bound", 32'(guard < 3000), 32'd1);
        repeat (3) cyc_model(1'b1);

        // underflow with a two-word prime, then refill without re-prime
        bus.enable = 1'b0;
        repeat (2) cyc_model(1'b0);
        model_push(16'h1B1B);
        model_push(16'h4E72);
        bus.enable = 1'b1;
        repeat (6) cyc_model(1'b0);
        v0 = nvalid;
        repeat (20) cyc_model(1'b1);
        chk("uf_valid_count", 32'(nvalid - v0), 32'd16);
        model_push(16'hC3A5);
        repeat (4) cyc_model(1'b0);
        repeat (10) cyc_model(1'b1);

        // flush while a read is pending
        bus.enable = 1'b0;
        repeat (2) cyc_model(1'b0);
        fifo_push(16'hDEAD);
        model_push(16'h0F0F);
        model_push(16'h9C63);
        bus.enable = 1'b1;
        cyc_model(1'b0);
        bus.enable = 1'b0;
        cyc_model(1'b0);
        chk("flush_rdnext", 32'(bus.fifo_read_next), 32'd0);
        bus.enable = 1'b1;
        repeat (6) cyc_model(1'b0);
        for (int i = 0; i < 36; i++) cyc_model(1'(i % 2));

        // async reset mid-run with strobes active
        for (int i = 0; i < 4; i++) model_push(16'($urandom));
        repeat (6) cyc_model(1'b0);
        repeat (3) cyc_model(1'b1);
        bus.sample_strobe = 1'b1;
        bus.enable        = 1'b0;
        reset_n           = 1'b0;
        #1;
        chk_zero("rst_run");
        fifo_q.delete();
        exp_q.delete();
        bus.fifo_empty = 1'b1;
        ucnt_m = '0;
        tick();
        tick();
        chk_zero("rst_hold");
        reset_n = 1'b1;
        model_push(16'h3C96);
        tick();
        chk("rst_rel_rdnext", 32'(bus.fifo_read_next), 32'd0);
        bus.enable = 1'b1;
        #1;
        chk("en_rdnext", 32'(bus.fifo_read_next), 32'd1);

        // saturation of the underflow counter
        model_push(16'h8421);
        repeat (6) cyc_model(1'b0);
        repeat (16) cyc_model(1'b1);
        repeat (100) cyc_model(1'b1);
        bus.sample_strobe = 1'b1;
        repeat (65500) tick();
        ucnt_m = (32'(ucnt_m) + 65500 > 65535) ? 16'hFFFF : ucnt_m + 16'd65500;
        repeat (3) cyc_model(1'b1);
        chk("sat_count", 32'(bus.underflow_count), 32'hFFFF);

        chk("no_overread", 32'(overread), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rtdf_sample_unpacker.md
Name: rtdf_sample_unpacker

Overview:
- Downstream consumer of the real-time data feed packet processor's stream FIFO (16-bit words, read side, single clock domain).
- Unpacks each word into fixed-width GPS IF samples and emits one sample per sample-rate strobe, replacing the RF front-end sample stream.
- Keeps a two-word buffer to hide FIFO read latency.
- Reports underflow when a strobe arrives with no sample available.

Parameters:
- SAMPLE_WIDTH, 2, bits per sample; must divide 16 (legal values 1, 2, 4, 8, 16); SPW = 16/SAMPLE_WIDTH samples per word.

Ports:
- clk  input  1  block clock; also the stream FIFO read clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  run enable; low flushes internal buffers.
- fifo_empty  input  1  stream FIFO empty flag.
- fifo_data  input  16  stream FIFO q; valid the cycle after fifo_read_next (normal-mode FIFO).
- fifo_read_next  output  1  FIFO read request (combinational).
- sample_strobe  input  1  one-cycle sample-rate tick.
- sample  output  SAMPLE_WIDTH  current sample (registered).
- sample_valid  output  1  one-cycle pulse, sample updated.
- underflow  output  1  one-cycle pulse, strobe missed.
- underflow_count  output  16  saturating count of missed strobes.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; sample=0, sample_valid=0, underflow=0, underflow_count=0.
  - cur_valid=0, next_valid=0, pending=0, idx=0.
- Internal storage:
  - cur word and idx (0..SPW-1).
  - next word with next_valid.
  - pending flag: read issued last cycle.
- Read rule: fifo_read_next = enable && !fifo_empty && !pending && !next_valid.
  - pending <= fifo_read_next each cycle.
- Arrival (pending=1): fifo_data is captured.
  - Goes into cur (idx<=0, cur_valid<=1) if cur is empty or being vacated this cycle and next_valid=0.
  - Otherwise goes into next (next_valid<=1).
- States:
  - IDLE: enable=0. Valid flags cleared; arriving pending data discarded; strobes ignored, no underflow. enable=1 -> PRIME.
  - PRIME: reads proceed; strobes ignored, no underflow. cur_valid && next_valid -> RUN.
  - RUN, strobe with cur_valid:
    - Next cycle: sample <= cur[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH], sample_valid=1.
    - idx<SPW-1: idx++.
    - idx==SPW-1: cur vacated. If next_valid, cur<=next, next_valid<=0, idx<=0. Else if arrival this cycle, cur<=fifo_data. Else cur_valid<=0.
  - RUN, strobe with cur_valid=0:
    - underflow=1 next cycle; underflow_count++ saturating at 16'hFFFF.
    - sample held; sample_valid=0; state stays RUN (no re-prime).
  - Any state, enable=0: -> IDLE next cycle. underflow_count retained; only reset clears it.
- Ordering: samples taken LSB first within a word. Bits [SAMPLE_WIDTH-1:0] first; bits [7:0] are the earlier wire byte.
- Latency: strobe at cycle t -> sample/sample_valid at t+1. First FIFO word to RUN takes at least 4 cycles after enable.
- At most one read is outstanding; next is never overwritten.
- Strobes on consecutive cycles are supported; throughput is 1 sample/cycle when the FIFO keeps up.

Test Plan:
- Reset/idle: reset_n=0 mid-RUN with strobes active -> all outputs 0 immediately; no fifo_read_next until enable=1.
- Basic unpack, SAMPLE_WIDTH=2: FIFO holds 16'hE41B, 16'h0000; enable; strobe every 4 cycles -> samples 3,2,1,0,0,1,2,3, then 0×8; each sample_valid exactly 1 cycle after its strobe.
- Back-to-back strobes every cycle, FIFO pre-filled with 64 words -> 512 consecutive sample_valid pulses, no underflow, no FIFO overread (fifo_read_next never with fifo_empty=1).
- Underflow: FIFO holds 1 word after PRIME (2 words total), strobe continues -> exactly 16 valid samples; then each strobe gives an underflow pulse and count 1,2,3…; refill FIFO -> samples resume from new word idx 0, with no re-PRIME.
- Saturation: force 70000 underflow strobes -> underflow_count=16'hFFFF and held.
- Flush: deassert enable while a read is pending -> pending word discarded; re-enable -> PRIME; first sample comes from the next FIFO word.
